// File: rtl/cplx_addsub_seq.sv
// cplx_addsub_seq: time-shares one 64-bit ripple adder to form re = ac - bd and im = ad + bc.
// Define CPLX_OVF_EN to add the registered signed-overflow flags ovf_re / ovf_im.

module rca64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  always_comb begin : ripple
    logic c;
    c   = cin;
    sum = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module cplx_addsub_seq #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] p_ac,
  input  logic [W-1:0] p_bd,
  input  logic [W-1:0] p_ad,
  input  logic [W-1:0] p_bc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] re,
  output logic [W-1:0] im,
  output logic         busy
`ifdef CPLX_OVF_EN
  ,
  output logic         ovf_re,
  output logic         ovf_im
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    ADD  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [W-1:0] ac_q, bd_q, ad_q, bc_q;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin;
  logic         add_cout_unused;
  logic         take;

  rca64 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout_unused)
  );

  always_comb begin
    state_nx  = state;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: in_ready = 1'b1;
      SUB: begin
        // a - b computed as a + ~b + 1 on the shared adder
        add_a   = ac_q;
        add_b   = ~bd_q;
        add_cin = 1'b1;
      end
      ADD: begin
        add_a = ad_q;
        add_b = bc_q;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
    take = in_valid & in_ready;
    case (state)
      IDLE:    if (take) state_nx = SUB;
      SUB:     state_nx = ADD;
      ADD:     state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = take ? SUB : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ac_q   <= '0;
      bd_q   <= '0;
      ad_q   <= '0;
      bc_q   <= '0;
      re     <= '0;
      im     <= '0;
`ifdef CPLX_OVF_EN
      ovf_re <= 1'b0;
      ovf_im <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (take) begin
        ac_q <= p_ac;
        bd_q <= p_bd;
        ad_q <= p_ad;
        bc_q <= p_bc;
      end
      if (state == SUB) begin
        re <= add_sum;
`ifdef CPLX_OVF_EN
        ovf_re <= (ac_q[W-1] != bd_q[W-1]) & (add_sum[W-1] != ac_q[W-1]);
`endif
      end
      if (state == ADD) begin
        im <= add_sum;
`ifdef CPLX_OVF_EN
        ovf_im <= (ad_q[W-1] == bc_q[W-1]) & (add_sum[W-1] != ad_q[W-1]);
`endif
      end
    end
  end

endmodule
